// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared types and constants for the stream_source playback block.
//   stream_state_t : playback FSM states (IDLE, RUN, GAP, DONE)
//   REPEAT_W       : width of the frame repeat count and completed-frame counter
//   GAP_W          : width of the inter-beat gap length
// -----------------------------------------------------------------------------
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } stream_state_t;

  localparam int REPEAT_W = 16;
  localparam int GAP_W    = 8;

endpackage : stream_pkg

// File: rtl/stream_source_mem.sv
// -----------------------------------------------------------------------------
// stream_source_mem
// Sample storage for stream_source: DEPTH x WIDTH register array with one
// synchronous write port and one asynchronous read port.
// Ports:
//   clk     in  clock
//   wr_en   in  write strobe; data is visible on the read port next cycle
//   wr_addr in  write address
//   wr_data in  write data
//   rd_addr in  read address (the playback pointer)
//   rd_data out combinational read data
// -----------------------------------------------------------------------------
module stream_source_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage arrays get no reset; clearing every entry would turn the
  // array into reset-loaded flops and the contents are loaded before use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : stream_source_mem

// File: rtl/stream_source.sv
// -----------------------------------------------------------------------------
// stream_source
// Valid/ready stream source replaying a loadable sample memory as framed
// beats of FRAME_LEN entries, with first-of-frame flag, programmable repeat
// count (0 = forever), optional idle gap after every accepted beat and a done
// indication.
// Optional feature macro: STREAM_SOURCE_LAST_EN adds data_out_lst, high on
// the last beat of a frame while it is presented.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   wr_en/addr/data      sample memory write port (any state)
//   start                begin playback (honoured in IDLE or DONE only)
//   repeats, gap         frames to play / idle cycles per beat, sampled at start
//   data_out, data_out_fst, data_out_vld, data_out_rdy   output stream
//   frame_cnt            completed frames (saturating)
//   busy, done           RUN-or-GAP / DONE status
//   data_out_lst         last beat of frame (STREAM_SOURCE_LAST_EN only)
// -----------------------------------------------------------------------------
module stream_source
  import stream_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 128,
  parameter int AW        = $clog2(DEPTH),
  parameter int FRAME_LEN = 108
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                start,
  input  logic [REPEAT_W-1:0] repeats,
  input  logic [GAP_W-1:0]    gap,
  output logic [WIDTH-1:0]    data_out,
  output logic                data_out_fst,
  output logic                data_out_vld,
  input  logic                data_out_rdy,
  output logic [REPEAT_W-1:0] frame_cnt,
  output logic                busy,
  output logic                done
`ifdef STREAM_SOURCE_LAST_EN
  ,
  output logic                data_out_lst
`endif
);

  if (FRAME_LEN < 1 || FRAME_LEN > DEPTH) begin : g_bad_frame_len
    $error("stream_source: FRAME_LEN must satisfy 1 <= FRAME_LEN <= DEPTH");
  end

  localparam logic [AW-1:0] LAST_PTR = AW'(FRAME_LEN - 1);

  stream_state_t       state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [REPEAT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [REPEAT_W-1:0] repeats_q, repeats_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic                at_last;
  logic                last_frame;
  logic [WIDTH-1:0]    rd_data;

  stream_source_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (ptr_q),
    .rd_data (rd_data)
  );

  // State register and playback registers.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed by the combinational blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      frame_cnt_q <= '0;
      repeats_q   <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      frame_cnt_q <= frame_cnt_d;
      repeats_q   <= repeats_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign at_last = (ptr_q == LAST_PTR);
  // Widened compare so a repeat count of 16'hFFFF still terminates.
  assign last_frame = (repeats_q != '0) &&
                      ({1'b0, frame_cnt_q} + 17'd1 == {1'b0, repeats_q});

  // Next-state logic.
  // NOTE: every signal gets a hold default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    frame_cnt_d = frame_cnt_q;
    repeats_d   = repeats_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          repeats_d   = repeats;
          gap_d       = gap;
          ptr_d       = '0;
          frame_cnt_d = '0;
          state_d     = RUN;
        end
      end

      RUN: begin
        // vld is constant 1 here, so an accept is simply rdy.
        if (data_out_rdy) begin
          ptr_d = at_last ? '0 : ptr_q + 1'b1;
          if (at_last && frame_cnt_q != '1) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
          if (at_last && last_frame) begin
            state_d = DONE;
          end else if (gap_q != '0) begin
            gap_cnt_d = gap_q;
            state_d   = GAP;
          end
        end
      end

      GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = RUN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only, never on data_out_rdy.
  always_comb begin
    data_out_vld = (state_q == RUN);
    data_out_fst = data_out_vld && (ptr_q == '0);
    busy         = (state_q == RUN) || (state_q == GAP);
    done         = (state_q == DONE);
    data_out     = rd_data;
`ifdef STREAM_SOURCE_LAST_EN
    data_out_lst = data_out_vld && at_last;
`endif
  end

  assign frame_cnt = frame_cnt_q;

endmodule : stream_source

// File: tb/tb_stream_source.sv
// -----------------------------------------------------------------------------
// tb_stream_source
// Directed bench for stream_source. Instance u_dut uses the default frame of
// 108 beats; instance u_dut1 uses FRAME_LEN = 1 to cover the single-beat
// frame, the 255-cycle gap and frame counter saturation in a short run.
// -----------------------------------------------------------------------------
module tb_stream_source;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;

  // Default-parameter instance.
  logic          wr_en;
  logic [6:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic          start;
  logic [15:0]   repeats;
  logic [7:0]    gap;
  logic [W-1:0]  data_out;
  logic          fst, vld, rdy;
  logic [15:0]   fcnt;
  logic          busy, done;
`ifdef STREAM_SOURCE_LAST_EN
  logic          lst;
`endif

  // FRAME_LEN = 1 instance.
  logic          wr_en_b;
  logic [0:0]    wr_addr_b;
  logic [W-1:0]  wr_data_b;
  logic          start_b;
  logic [15:0]   repeats_b;
  logic [7:0]    gap_b;
  logic [W-1:0]  data_out_b;
  logic          fst_b, vld_b, rdy_b;
  logic [15:0]   fcnt_b;
  logic          busy_b, done_b;
`ifdef STREAM_SOURCE_LAST_EN
  logic          lst_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_source u_dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .repeats      (repeats),
    .gap          (gap),
    .data_out     (data_out),
    .data_out_fst (fst),
    .data_out_vld (vld),
    .data_out_rdy (rdy),
    .frame_cnt    (fcnt),
    .busy         (busy),
    .done         (done)
`ifdef STREAM_SOURCE_LAST_EN
    ,
    .data_out_lst (lst)
`endif
  );

  stream_source #(
    .WIDTH     (W),
    .DEPTH     (2),
    .FRAME_LEN (1)
  ) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en_b),
    .wr_addr      (wr_addr_b),
    .wr_data      (wr_data_b),
    .start        (start_b),
    .repeats      (repeats_b),
    .gap          (gap_b),
    .data_out     (data_out_b),
    .data_out_fst (fst_b),
    .data_out_vld (vld_b),
    .data_out_rdy (rdy_b),
    .frame_cnt    (fcnt_b),
    .busy         (busy_b),
    .done         (done_b)
`ifdef STREAM_SOURCE_LAST_EN
    ,
    .data_out_lst (lst_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int bad;

    reset   = 1'b1;
    wr_en   = 1'b0; wr_addr   = '0; wr_data   = '0;
    start   = 1'b0; repeats   = '0; gap       = '0; rdy   = 1'b0;
    wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    start_b = 1'b0; repeats_b = '0; gap_b     = '0; rdy_b = 1'b0;
    tick();
    tick();

    // ---- reset state ----
    check("rst_vld",  vld,  0);
    check("rst_fst",  fst,  0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fcnt", fcnt, 0);
    check("rst_vld_b", vld_b, 0);
    reset = 1'b0;

    // ---- load mem[i] = i, and mem[0] = 0x55 in the single-beat instance ----
    for (int i = 0; i < 108; i++) begin
      wr_en = 1'b1; wr_addr = 7'(i); wr_data = W'(i);
      tick();
    end
    wr_en = 1'b0;
    wr_en_b = 1'b1; wr_addr_b = 1'b0; wr_data_b = 32'h55;
    tick();
    wr_en_b = 1'b0;
    check("idle_after_load", busy, 0);

    // ---- repeats=2, gap=0, rdy=1: 216 back-to-back beats ----
    repeats = 16'd2; gap = 8'd0; rdy = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 216; k++) begin
      check("s1_vld",  vld, 1);
      check("s1_data", data_out, 32'(k % 108));
      check("s1_fst",  fst, 32'((k % 108) == 0));
      check("s1_fcnt", fcnt, 32'(k / 108));
      tick();
    end
    check("s1_done", done, 1);
    check("s1_vld_end", vld, 0);
    check("s1_busy_end", busy, 0);
    check("s1_fcnt_end", fcnt, 2);

    // ---- repeats=1, gap=3: three idle cycles after every beat ----
    repeats = 16'd1; gap = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 108; k++) begin
      check("s2_vld",  vld, 1);
      check("s2_data", data_out, 32'(k));
      tick();
      if (k < 107) begin
        for (int g = 0; g < 3; g++) begin
          check("s2_gap_vld",  vld, 0);
          check("s2_gap_busy", busy, 1);
          tick();
        end
      end
    end
    check("s2_done", done, 1);
    check("s2_fcnt", fcnt, 1);

    // ---- repeats=1, rdy toggling 1010...: nothing lost, stable on stall ----
    repeats = 16'd1; gap = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    for (int c = 0; c < 300 && idx < 108; c++) begin
      rdy = (c % 2 == 0);
      check("s3_vld",  vld, 1);
      check("s3_data", data_out, 32'(idx));
      check("s3_fst",  fst, 32'(idx == 0));
`ifdef STREAM_SOURCE_LAST_EN
      check("s3_lst",  lst, 32'(idx == 107));
`endif
      if (rdy) idx++;
      tick();
    end
    rdy = 1'b1;
    check("s3_count", idx, 108);
    check("s3_done", done, 1);

    // ---- last beat held across a 5-cycle stall ----
    repeats = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 107; k++) begin
      check("s4_data", data_out, 32'(k));
`ifdef STREAM_SOURCE_LAST_EN
      if (k == 106) check("s4_lst_before", lst, 0);
`endif
      tick();
    end
    rdy = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check("s4_stall_vld",  vld, 1);
      check("s4_stall_data", data_out, 107);
      check("s4_stall_fst",  fst, 0);
`ifdef STREAM_SOURCE_LAST_EN
      check("s4_stall_lst",  lst, 1);
`endif
      tick();
    end
    rdy = 1'b1;
    check("s4_release_data", data_out, 107);
    tick();
    check("s4_done", done, 1);
`ifdef STREAM_SOURCE_LAST_EN
    check("s4_lst_after", lst, 0);
`endif

    // ---- reset from DONE clears status and counter ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_done_clr", done, 0);
    check("rst_fcnt_clr", fcnt, 0);

    // ---- write while idle, then reset mid-frame at beat 50 ----
    wr_en = 1'b1; wr_addr = 7'd3; wr_data = 32'hCAFE_F00D;
    tick();
    wr_en = 1'b0;
    repeats = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      check("s5_data", data_out, (k == 3) ? 32'hCAFE_F00D : 32'(k));
      tick();
    end
    check("s5_beat50", data_out, 50);
    reset = 1'b1; start = 1'b1;
    tick();
    check("s5_rst_vld",  vld, 0);
    check("s5_rst_fcnt", fcnt, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_fst",  fst, 0);
    tick();
    check("s5_rst_start_vld", vld, 0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("s5_idle_vld", vld, 0);
    repeats = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("s5_restart_vld",  vld, 1);
    check("s5_restart_data", data_out, 0);
    check("s5_restart_fst",  fst, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // ---- FRAME_LEN = 1: repeats=3, every beat is first of frame ----
    repeats_b = 16'd3; gap_b = 8'd0; rdy_b = 1'b1; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("b1_vld",  vld_b, 1);
      check("b1_fst",  fst_b, 1);
      check("b1_data", data_out_b, 32'h55);
      check("b1_fcnt", fcnt_b, 32'(k));
      tick();
    end
    check("b1_done", done_b, 1);
    check("b1_fcnt_end", fcnt_b, 3);

    // ---- gap = 255 between two beats ----
    repeats_b = 16'd2; gap_b = 8'd255; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b2_vld0", vld_b, 1);
    tick();
    bad = 0;
    for (int g = 0; g < 255; g++) begin
      if (vld_b !== 1'b0 || busy_b !== 1'b1) bad++;
      tick();
    end
    check("b2_gap_idle_cycles", bad, 0);
    check("b2_vld1", vld_b, 1);
    check("b2_fcnt1", fcnt_b, 1);
    tick();
    check("b2_done", done_b, 1);

    // ---- repeats = 0: runs forever, counter saturates, start ignored ----
    repeats_b = 16'd0; gap_b = 8'd0; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    bad = 0;
    for (int k = 0; k < 70000; k++) begin
      start_b = (k == 1000 || k == 66000);
      if (vld_b !== 1'b1) bad++;
      if (k == 0 || k == 500 || k == 2000 || k == 65534 || k == 65535 || k == 69999) begin
        check("b3_fcnt", fcnt_b, (k > 65535) ? 32'd65535 : 32'(k));
      end
      tick();
    end
    start_b = 1'b0;
    check("b3_vld_drops", bad, 0);
    check("b3_fcnt_sat", fcnt_b, 65535);
    check("b3_busy", busy_b, 1);
    check("b3_not_done", done_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stream_source
